// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// Holds the FSM and port encodings plus the byte-merge and fault-check functions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RMW  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  localparam int WORD_BYTES = 4;

  // The memory has no byte enables, so each lane is taken from the new data or the old word.
  function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                              input logic [31:0] wdata,
                                              input logic [31:0] old);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Addresses arrive zero-extended to 64 bits so one function serves any ADDR_W/DEPTH.
  function automatic logic access_fault(input logic [63:0] addr,
                                        input logic [63:0] byte_limit,
                                        input logic        is_store,
                                        input logic [3:0]  be);
    return (addr[1:0] != 2'b00) || (addr >= byte_limit) || (is_store && (be == 4'h0));
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request/response bundle between the core's fetch and load/store ports and the arbiter.
// master = core side, slave = arbiter side.
interface mem_arb_if #(
  parameter int ADDR_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  i_ready, i_rvalid, i_rdata, i_err,
    input  d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output i_ready, i_rvalid, i_rdata, i_err,
    output d_ready, d_rvalid, d_rdata, d_err
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant between the fetch and data ports.
// On contention the port that did not win last time is granted; last_grant moves on every grant.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  port_t last_grant;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (req_i && req_d) begin
        if (last_grant == INSTR) gnt_d = 1'b1;
        else                     gnt_i = 1'b1;
      end else if (req_i) begin
        gnt_i = 1'b1;
      end else if (req_d) begin
        gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= DATA;
    end else if (gnt_i) begin
      last_grant <= INSTR;
    end else if (gnt_d) begin
      last_grant <= DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store,
// converting byte addresses to word indices and doing sub-word stores as read-modify-write.
//
// state | meaning
// IDLE  | may accept one request; reads and full stores issue to memory in the accept cycle
// RMW   | partial store: old word is on mem_dout, write back the lane-merged word
// RESP  | rvalid pulse to the granted port; no new accept this cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arb_if.slave      bus,
  output logic          mem_cs,
  output logic          mem_we,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'(WORD_BYTES);

  state_t state_q, state_d;

  port_t       port_q;
  logic        we_q;
  logic        err_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [AW-1:0] widx_q;

  logic              gnt_i, gnt_d, accept, idle_en;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we, acc_fault, acc_full;
  logic [AW-1:0]     acc_idx;
  logic              resp;
  logic [31:0]       rd_word;

  // Gating with rst_n keeps ready and mem_* low while reset is held, even with requests pending.
  assign idle_en = rst_n && (state_q == IDLE);

  mem_arb_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle_en),
    .req_i (bus.i_req),
    .req_d (bus.d_req),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  assign accept    = gnt_i | gnt_d;
  assign acc_addr  = gnt_d ? bus.d_addr : bus.i_addr;
  assign acc_we    = gnt_d & bus.d_we;
  assign acc_full  = (bus.d_be == 4'hF);
  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_fault = access_fault(64'(acc_addr), BYTE_LIMIT, acc_we, bus.d_be);

  assign bus.i_ready = gnt_i;
  assign bus.d_ready = gnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= DATA;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= '0;
      widx_q  <= '0;
    end else if (accept) begin
      port_q  <= gnt_i ? INSTR : DATA;
      we_q    <= acc_we;
      err_q   <= acc_fault;
      be_q    <= bus.d_be;
      wdata_q <= bus.d_wdata;
      widx_q  <= acc_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_read = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          if (!acc_fault) begin
            mem_cs   = 1'b1;
            mem_addr = acc_idx;
            if (acc_we && acc_full) begin
              mem_we  = 1'b1;
              mem_din = bus.d_wdata;
            end else begin
              mem_read = 1'b1;
              if (acc_we) state_d = RMW;
            end
          end
        end
      end
      RMW: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = widx_q;
        mem_din  = merge_bytes(be_q, wdata_q, mem_dout);
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign resp    = (state_q == RESP);
  // Only a non-faulting read leaves valid data on mem_dout; stores and faults return zero.
  assign rd_word = (resp && !we_q && !err_q) ? mem_dout : 32'h0;

  assign bus.i_rvalid = resp && (port_q == INSTR);
  assign bus.d_rvalid = resp && (port_q == DATA);
  assign bus.i_err    = bus.i_rvalid && err_q;
  assign bus.d_err    = bus.d_rvalid && err_q;
  assign bus.i_rdata  = bus.i_rvalid ? rd_word : 32'h0;
  assign bus.d_rdata  = bus.d_rvalid ? rd_word : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, cycle-level corner sequences and
// randomized transactions checked against a word-array reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(ADDR_W)) bus ();

  logic          mem_cs, mem_we, mem_read;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_read (mem_read),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Memory instance model with one-cycle registered read and a preload port.
  logic [31:0]   mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  always @(posedge clk) begin
    if (mem_cs && mem_read) mem_dout <= mem[mem_addr];
    if (mem_cs && mem_we)   mem[mem_addr] <= mem_din;
    if (pre_we)             mem[pre_addr] <= pre_data;
  end

  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int failures = 0;
  int dbl_ready = 0;

  always @(negedge clk) if (bus.i_ready && bus.d_ready) dbl_ready++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = AW'(idx);
    pre_data = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid,
                           bus.i_err, bus.d_err, mem_cs, mem_we, mem_read}, 0);
    check({tag, "_i_rdata"}, bus.i_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_din"}, mem_din, 0);
  endtask

  // One complete transaction on one port; returns response data, latency and memory-busy cycles.
  task automatic txn(input bit port_d, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err,
                     output int lat, output int cs_cycles);
    int  waits;
    int  other_pulses;
    bit  got;
    rdata = '0; err = 1'b0; lat = -1; cs_cycles = 0; other_pulses = 0; got = 1'b0;
    @(negedge clk);
    if (port_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    #1;
    waits = 0;
    while (!(port_d ? bus.d_ready : bus.i_ready) && waits < 8) begin
      @(negedge clk); #1; waits++;
    end
    if (!(port_d ? bus.d_ready : bus.i_ready)) begin
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready addr=%0h", addr);
      return;
    end
    cs_cycles = int'(mem_cs);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
    bus.d_be = 4'($urandom); bus.d_we = 1'($urandom);
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      cs_cycles += int'(mem_cs);
      if (port_d ? bus.i_rvalid : bus.d_rvalid) other_pulses++;
      if (port_d ? bus.d_rvalid : bus.i_rvalid) begin
        got = 1'b1;
        lat = c;
        rdata = port_d ? bus.d_rdata : bus.i_rdata;
        err = port_d ? bus.d_err : bus.i_err;
      end
    end
    check("other_rvalid_quiet", other_pulses, 0);
  endtask

  typedef struct {
    bit          port_d;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat, csc;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;

    vecs[0]  = '{0, 0, 4'h0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 1};
    vecs[1]  = '{1, 1, 4'hF, 32'h20,       32'h12345678, 32'h0,        0, 1};
    vecs[2]  = '{1, 0, 4'h0, 32'h20,       32'h0,        32'h12345678, 0, 1};
    vecs[3]  = '{1, 1, 4'h2, 32'h20,       32'h0000AA00, 32'h0,        0, 2};
    vecs[4]  = '{1, 0, 4'hF, 32'h20,       32'hFFFFFFFF, 32'h1234AA78, 0, 1};
    vecs[5]  = '{0, 0, 4'h0, 32'h3,        32'h0,        32'h0,        1, 1};
    vecs[6]  = '{1, 0, 4'h0, 32'h1000,     32'h0,        32'h0,        1, 1};
    vecs[7]  = '{1, 0, 4'h0, 32'hFFC,      32'h0,        32'hCAFEF00D, 0, 1};
    vecs[8]  = '{1, 1, 4'h0, 32'h40,       32'h11111111, 32'h0,        1, 1};
    vecs[9]  = '{1, 1, 4'h9, 32'h10,       32'hAA0000BB, 32'h0,        0, 2};
    vecs[10] = '{0, 0, 4'h0, 32'h10,       32'h0,        32'hAAADBEBB, 0, 1};
    vecs[11] = '{1, 1, 4'hF, 32'h22,       32'h55555555, 32'h0,        1, 1};
    vecs[12] = '{1, 0, 4'h0, 32'h10000000, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{0, 0, 4'h0, 32'hFFC,      32'h0,        32'hCAFEF00D, 0, 1};

    // Reset with both ports requesting: nothing may leak out.
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_addr = 32'h20;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    preload(4, 32'hDEADBEEF);
    preload(8, 32'h11223344);
    preload(1023, 32'hCAFEF00D);

    // Both ports held from reset release: I first, then alternating every 2 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("alt_i_ready_%0d", k), bus.i_ready, (k % 4) == 0);
      check($sformatf("alt_d_ready_%0d", k), bus.d_ready, (k % 4) == 2);
      check($sformatf("alt_i_rvalid_%0d", k), bus.i_rvalid, (k % 4) == 1);
      check($sformatf("alt_d_rvalid_%0d", k), bus.d_rvalid, (k % 4) == 3);
      if (k == 1) check("alt_i_rdata", bus.i_rdata, 32'hDEADBEEF);
      if (k == 3) check("alt_d_rdata", bus.d_rdata, 32'h11223344);
      if (k == 7) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end else begin
        @(negedge clk); #1;
      end
    end

    // Directed vector table.
    for (int v = 0; v < 14; v++) begin
      txn(vecs[v].port_d, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rdata, err, lat, csc);
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_mem_cycles", v), csc, vecs[v].exp_err ? 0 : vecs[v].exp_lat);
    end

    // Full store cycle detail.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
    #1;
    check("full_ready", bus.d_ready, 1);
    check("full_c0_ctrl", {mem_cs, mem_we, mem_read}, 3'b110);
    check("full_c0_din", mem_din, 32'h12345678);
    check("full_c0_addr", mem_addr, 8);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("full_c1_rvalid", {bus.d_rvalid, bus.d_err, bus.i_rvalid}, 3'b100);

    // Partial store cycle detail: read, merged write, then response.
    preload(8, 32'h11223344);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0010; bus.d_addr = 32'h20; bus.d_wdata = 32'h0000AA00;
    #1;
    check("rmw_ready", bus.d_ready, 1);
    check("rmw_c0_ctrl", {mem_cs, mem_we, mem_read}, 3'b101);
    check("rmw_c0_addr", mem_addr, 8);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.d_wdata = 32'hFFFFFFFF; bus.d_be = 4'hF;
    @(negedge clk);
    check("rmw_c1_ctrl", {mem_cs, mem_we, mem_read, bus.d_rvalid}, 4'b1100);
    check("rmw_c1_din", mem_din, 32'h1122AA44);
    @(negedge clk);
    check("rmw_c2_resp", {bus.d_rvalid, bus.d_err, mem_cs}, 3'b100);
    check("rmw_c2_rdata", bus.d_rdata, 0);
    check("rmw_mem_word", mem[8], 32'h1122AA44);

    // Randomized transactions against the reference word array.
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(1023, $urandom);
    for (int t = 0; t < 300; t++) begin
      bit          pd, st, fault;
      logic [3:0]  be;
      logic [31:0] addr, wd, exp_rd, mask;
      int          r, exp_lat, idx;
      pd = 1'($urandom_range(0, 1));
      st = pd && ($urandom_range(0, 1) == 1);
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) be = 4'hF;
      wd = $urandom;
      addr = 32'($urandom_range(0, 63)) * 4;
      r = $urandom_range(0, 19);
      if (r == 0) addr = addr + 32'($urandom_range(1, 3));
      if (r == 1) addr = 32'h1000 + 32'($urandom_range(0, 4000)) * 4;
      if (r == 2) addr = 32'hFFC;
      fault = (addr % 4 != 0) || (addr >= 32'(DEPTH * WORD_BYTES)) || (st && be == 4'h0);
      idx = int'(addr / 4);
      exp_rd = 32'h0;
      exp_lat = 1;
      if (!fault) begin
        if (st) begin
          mask = 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
          ref_mem[idx] = (ref_mem[idx] & ~mask) | (wd & mask);
          if (be != 4'hF) exp_lat = 2;
        end else begin
          exp_rd = ref_mem[idx];
        end
      end
      txn(pd, st, be, addr, wd, rdata, err, lat, csc);
      check($sformatf("rnd%0d_rdata a=%0h", t, addr), rdata, exp_rd);
      check($sformatf("rnd%0d_err a=%0h", t, addr), err, fault);
      check($sformatf("rnd%0d_lat a=%0h", t, addr), lat, exp_lat);
    end

    // Reset while in RMW: outputs drop at once, write never lands, INSTR wins next.
    preload(12, 32'h55555555);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0001; bus.d_addr = 32'h30; bus.d_wdata = 32'h000000FF;
    #1;
    check("rstrmw_ready", bus.d_ready, 1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    check("rstrmw_in_rmw", {mem_cs, mem_we}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_all_zero("rstrmw");
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    #1;
    check("rstrmw_held_ready", {bus.i_ready, bus.d_ready}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", {bus.i_ready, bus.d_ready}, 2'b10);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b10);
    check("post_rst_rdata", bus.i_rdata, ref_mem[4]);
    check("rstrmw_word_kept", mem[12], 32'h55555555);

    repeat (2) @(negedge clk);
    check("no_double_ready", dbl_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous word memory between the multicycle core's instruction-fetch port (read-only) and its load/store port.
- Performs round-robin arbitration and converts byte addresses to word indices.
- Implements sub-word stores as read-modify-write, because the memory has no byte enables.
- Sits between the core's control unit and the memory instance. Drives the memory's cs/we/read/addr/dataIn and consumes its registered dataOut (one-cycle read latency).

Parameters:
- DEPTH, 1024, memory depth in 32-bit words; word index width AW = $clog2(DEPTH).
- ADDR_W, 32, requester byte-address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until accepted
- i_addr  in  ADDR_W  fetch byte address
- i_ready  out  1  fetch accepted this cycle
- i_rvalid  out  1  one-cycle pulse: i_rdata/i_err valid
- i_rdata  out  32  fetched word
- i_err  out  1  access fault, qualified by i_rvalid
- d_req  in  1  data request; held with payload until accepted
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables (ignored for loads)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, lanes already positioned
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data / store completion
- d_rdata  out  32  loaded word (0 for stores)
- d_err  out  1  access fault, qualified by d_rvalid
- mem_cs, mem_we, mem_read  out  1 each  memory controls
- mem_addr  out  AW  word index
- mem_din  out  32  memory write data
- mem_dout  in  32  memory read data, valid the cycle after a read

Behaviour:
- Reset: state IDLE, last_grant = DATA. All outputs are 0 (ready, rvalid, err, rdata, mem_*). Reset mid-access abandons the access; a write already issued stays committed.
- Word index = addr[AW+1:2]. Fault when:
  - addr[1:0] != 0, or
  - addr >= DEPTH*4, or
  - a store has d_be == 0.
- A faulting request is accepted with no memory access. rvalid+err pulse the next cycle; rdata = 0.
- Accept only in IDLE; ready is combinational, at most one per cycle. Grant rules:
  - Both requesting: grant the port not equal to last_grant.
  - Otherwise: grant the sole requester.
  - last_grant updates on every accept.
- Payload is captured into registers on accept; later input changes are ignored.
- mem_* are combinational from state and the captured or accepting request. mem_cs = 0 whenever no access is issued.
- FSM:
  - IDLE, read accepted (fetch or load): cs=1, read=1 in the accept cycle -> RESP.
  - IDLE, store with be=4'hF: cs=1, we=1, din=wdata in the accept cycle -> RESP.
  - IDLE, store with partial be: cs=1, read=1 in the accept cycle -> RMW.
  - RMW: cs=1, we=1. mem_din = per byte lane, be ? wdata : mem_dout -> RESP.
  - RESP: granted port's rvalid=1; rdata = mem_dout for reads, 0 for stores -> IDLE. No accept in RESP.
- Latency:
  - Read / full store: response 1 cycle after accept.
  - Partial store: response 2 cycles after accept.
  - Fault: response 1 cycle after accept.
- The other port's rvalid stays 0 throughout.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, RMW, RESP}
  - typedef enum port_t {INSTR, DATA}
  - constant WORD_BYTES = 4
- One sub-module, mem_arb_rr: 2-way round-robin grant with the last_grant register.
- Byte-merge and fault check stay as functions in the package.

Test Plan:
- Memory preloaded word[4]=32'hDEADBEEF; i_req, i_addr=0x10 -> i_ready in cycle 0; i_rvalid, i_rdata=DEADBEEF in cycle 1; d_* quiet.
- d_req store, d_addr=0x20, d_be=F, d_wdata=0x12345678 -> mem_we in cycle 0, d_rvalid in cycle 1; a later load of 0x20 returns 0x12345678.
- word[8]=0x11223344; store d_be=4'b0010, d_wdata=0x0000AA00 -> read in cycle 0, write 0x1122AA44 in cycle 1, d_rvalid in cycle 2.
- i_req and d_req held continuously after reset -> grants alternate I, D, I, D, each 2 cycles apart; no double ready.
- i_addr=0x3 -> i_err=1 after 1 cycle, mem_cs never asserted. d_addr=DEPTH*4 load -> d_err=1.
- rst_n low during RMW -> all outputs 0 immediately. After release, IDLE; the first simultaneous request grants INSTR; target word unchanged.
